// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction fetch unit. It issues sequential word addresses to
//               a ROM with one cycle of read latency and queues the returned
//               words with their addresses in a 2-entry FIFO. The consumer side
//               uses a valid/ready handshake. Fetch can be redirected to a new
//               PC, which flushes queued and in-flight work, and can be paused
//               with halt.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  output logic        rom_en,
  input  logic [31:0] rom_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
);

  // Two queue slots are enough to keep a back-to-back consumer fed when the
  // ROM has one cycle of read latency.
  localparam int unsigned FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;                   // next address to fetch
  logic        inflight_q, inflight_d;       // a ROM read was issued last cycle
  logic [31:0] inflight_pc_q, inflight_pc_d; // address of that read
  logic [1:0]  count_q, count_d;             // FIFO occupancy, 0..2
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] fifo_pc_q   [FIFO_DEPTH];
  logic [31:0] fifo_pc_d   [FIFO_DEPTH];
  logic [31:0] fifo_inst_q [FIFO_DEPTH];
  logic [31:0] fifo_inst_d [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // Internal handshakes
  // --------------------------------------------------------------------------
  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;

  // Consumer-side outputs come straight from the FIFO head; the data fields
  // read as zero whenever the queue is empty.
  always_comb begin
    inst_valid = (count_q != 2'd0);
    inst_out   = inst_valid ? fifo_inst_q[rd_ptr_q] : 32'h0;
    inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0;
  end

  // Issue decision: occupancy counts queued entries plus the response still
  // on its way, minus the entry leaving this cycle. Keeping it below the
  // queue depth guarantees every response has a free slot when it arrives.
  always_comb begin
    pop       = inst_valid & inst_ready;
    push      = inflight_q & ~redirect;
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = (state_q == S_RUN) && !halt && !redirect &&
                (occupancy < 3'(FIFO_DEPTH));
    rom_en    = issue;
    rom_addr  = pc_q;
  end

  // Next-state logic for the FSM, fetch PC, in-flight tracker and FIFO.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? pc_q : inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_inst_d   = fifo_inst_q;

    case (state_q)
      S_INIT:   state_d = S_RUN;
      S_RUN:    state_d = halt ? S_HALTED : S_RUN;
      S_HALTED: state_d = halt ? S_HALTED : S_RUN;
      default:  state_d = S_INIT;
    endcase

    if (redirect) begin
      // Redirect overrides everything: drop the queue, ignore the response
      // of the previous request and restart fetch at the new target.
      state_d  = S_RUN;
      pc_d     = redirect_pc;
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (issue) begin
        pc_d = pc_q + PC_STEP;  // 32-bit wrap is intended
      end
      if (push) begin
        fifo_pc_d[wr_ptr_q]   = inflight_pc_q;
        fifo_inst_d[wr_ptr_q] = rom_data;
        wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Register all state; reset acts immediately and discards any pending work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_INIT;
      pc_q           <= RESET_PC;
      inflight_q     <= 1'b0;
      inflight_pc_q  <= 32'h0;
      count_q        <= 2'd0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      fifo_pc_q[0]   <= 32'h0;
      fifo_pc_q[1]   <= 32'h0;
      fifo_inst_q[0] <= 32'h0;
      fifo_inst_q[1] <= 32'h0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      inflight_q     <= inflight_d;
      inflight_pc_q  <= inflight_pc_d;
      count_q        <= count_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      fifo_pc_q      <= fifo_pc_d;
      fifo_inst_q    <= fifo_inst_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Directed self-checking testbench for inst_fetch. A ROM model
//               returns data equal to its address one cycle after rom_en.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rom_addr;
  logic        rom_en;
  logic [31:0] rom_data = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  int checks = 0;
  int errors = 0;

  inst_fetch #(
    .RESET_PC (32'h0),
    .PC_STEP  (32'd1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr),
    .rom_en      (rom_en),
    .rom_data    (rom_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc)
  );

  always #5 clk = ~clk;

  // ROM model: one cycle read latency, data equals address
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_addr;
  end

  // Each cycle: inputs set at posedge+1, outputs checked at posedge+2
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges, releases it at posedge+1 (cycle k=0)
  task automatic do_reset(input logic ready);
    rst = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    inst_ready = ready;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; halt = 1'b0; redirect = 1'b0; inst_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en: got %b expected 0", rom_en); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
    checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr: got %h expected 00000000", rom_addr); end
    checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst_out: got %h expected 00000000", inst_out); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h expected 00000000", inst_pc); end
  endtask

  // Free-running consumer: addresses 0,1,2..., first instruction at k=3
  task automatic test_stream();
    do_reset(1'b1);
    for (int k = 0; k < 12; k++) begin
      #1;
      checks++; if (rom_en !== (k >= 1)) begin errors++; $display("FAIL stream_rom_en k=%0d: got %b expected %b", k, rom_en, (k >= 1)); end
      if (k >= 1) begin
        checks++; if (rom_addr !== 32'(k - 1)) begin errors++; $display("FAIL stream_rom_addr k=%0d: got %h expected %h", k, rom_addr, 32'(k - 1)); end
      end
      checks++; if (inst_valid !== (k >= 3)) begin errors++; $display("FAIL stream_valid k=%0d: got %b expected %b", k, inst_valid, (k >= 3)); end
      if (k >= 3) begin
        checks++; if (inst_pc !== 32'(k - 3) || inst_out !== 32'(k - 3)) begin errors++; $display("FAIL stream_inst k=%0d: got pc=%h out=%h expected %h", k, inst_pc, inst_out, 32'(k - 3)); end
      end
      step();
    end
  endtask

  // Consumer stalled after reset: queue fills with pc 0,1 and fetch stops
  task automatic test_stall();
    do_reset(1'b0);
    for (int k = 0; k < 11; k++) begin
      if (k == 8) inst_ready = 1'b1;
      #1;
      if (k >= 3 && k <= 7) begin
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL stall_rom_en k=%0d: got %b expected 0", k, rom_en); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_out !== 32'h0) begin errors++; $display("FAIL stall_head k=%0d: got v=%b pc=%h out=%h expected v=1 pc=0 out=0", k, inst_valid, inst_pc, inst_out); end
        checks++; if (rom_addr !== 32'h2) begin errors++; $display("FAIL stall_rom_addr k=%0d: got %h expected 00000002", k, rom_addr); end
      end
      if (k == 8) begin
        checks++; if (rom_en !== 1'b1 || rom_addr !== 32'h2) begin errors++; $display("FAIL stall_resume_fetch: got en=%b addr=%h expected en=1 addr=2", rom_en, rom_addr); end
      end
      if (k >= 8) begin
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(k - 8) || inst_out !== 32'(k - 8)) begin errors++; $display("FAIL stall_drain k=%0d: got v=%b pc=%h out=%h expected pc=%h", k, inst_valid, inst_pc, inst_out, 32'(k - 8)); end
      end
      step();
    end
  endtask

  // Redirect while a read is in flight: stale response must be dropped
  task automatic test_redirect();
    do_reset(1'b1);
    repeat (6) step();
    redirect = 1'b1; redirect_pc = 32'h40;
    #1;
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL redirect_cycle_rom_en: got %b expected 0", rom_en); end
    step();
    redirect = 1'b0;
    for (int r = 1; r < 6; r++) begin
      #1;
      if (r <= 2) begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redirect_stale r=%0d: got valid=%b pc=%h expected valid=0", r, inst_valid, inst_pc); end
        checks++; if (rom_en !== 1'b1 || rom_addr !== 32'h40 + 32'(r - 1)) begin errors++; $display("FAIL redirect_fetch r=%0d: got en=%b addr=%h expected %h", r, rom_en, rom_addr, 32'h40 + 32'(r - 1)); end
      end else begin
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 + 32'(r - 3) || inst_out !== 32'h40 + 32'(r - 3)) begin errors++; $display("FAIL redirect_inst r=%0d: got v=%b pc=%h out=%h expected %h", r, inst_valid, inst_pc, inst_out, 32'h40 + 32'(r - 3)); end
      end
      step();
    end
  endtask

  // Halt for 4 cycles: no fetch, queue drains, fetch resumes at pc 5
  task automatic test_halt();
    logic found;
    do_reset(1'b1);
    repeat (6) step();
    halt = 1'b1;
    for (int h = 0; h < 4; h++) begin
      #1;
      checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL halt_rom_en h=%0d: got %b expected 0", h, rom_en); end
      if (h < 2) begin
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(3 + h)) begin errors++; $display("FAIL halt_drain h=%0d: got v=%b pc=%h expected %h", h, inst_valid, inst_pc, 32'(3 + h)); end
      end else begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL halt_empty h=%0d: got %b expected 0", h, inst_valid); end
      end
      step();
    end
    halt = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 6 && !found; n++) begin
      #1;
      if (rom_en === 1'b1) found = 1'b1;
      else step();
    end
    checks++; if (!found || rom_addr !== 32'h5) begin errors++; $display("FAIL halt_resume_addr: got en=%b addr=%h expected en=1 addr=5", found, rom_addr); end
    step();
    found = 1'b0;
    for (int n = 0; n < 6 && !found; n++) begin
      #1;
      if (inst_valid === 1'b1) found = 1'b1;
      else step();
    end
    checks++; if (!found || inst_pc !== 32'h5) begin errors++; $display("FAIL halt_resume_inst0: got v=%b pc=%h expected pc=5", found, inst_pc); end
    step();
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h6) begin errors++; $display("FAIL halt_resume_inst1: got v=%b pc=%h expected pc=6", inst_valid, inst_pc); end
    step();
  endtask

  // Redirect to the top of the address space: the fetch PC wraps to zero
  task automatic test_wrap();
    logic found;
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'hFFFFFFFF; exp_seq[1] = 32'h0; exp_seq[2] = 32'h1;
    do_reset(1'b1);
    repeat (5) step();
    redirect = 1'b1; redirect_pc = 32'hFFFFFFFF;
    step();
    redirect = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 6 && !found; n++) begin
      #1;
      if (inst_valid === 1'b1) found = 1'b1;
      else step();
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin step(); #1; end
      checks++; if (!found || inst_valid !== 1'b1 || inst_pc !== exp_seq[i] || inst_out !== exp_seq[i]) begin errors++; $display("FAIL wrap_seq i=%0d: got v=%b pc=%h out=%h expected %h", i, inst_valid, inst_pc, inst_out, exp_seq[i]); end
    end
    step();
  endtask

  // Irregular consumer: every accepted instruction must be the next in order
  task automatic test_back_to_back();
    logic [15:0] pattern;
    logic [31:0] exp_pc;
    int          accepted;
    pattern  = 16'b1011_0010_1110_0101;
    exp_pc   = 32'h0;
    accepted = 0;
    do_reset(1'b0);
    for (int c = 0; c < 48; c++) begin
      inst_ready = pattern[c % 16];
      #1;
      if (inst_valid === 1'b1 && inst_ready) begin
        checks++; if (inst_pc !== exp_pc || inst_out !== exp_pc) begin errors++; $display("FAIL b2b_order c=%0d: got pc=%h out=%h expected %h", c, inst_pc, inst_out, exp_pc); end
        exp_pc = exp_pc + 32'd1;
        accepted++;
      end
      step();
    end
    // 27 ready cycles in 48; at least 20 must have found an instruction
    checks++; if (accepted < 20) begin errors++; $display("FAIL b2b_throughput: got %0d accepted expected at least 20", accepted); end
    inst_ready = 1'b1;
  endtask

  // Reset pulsed between edges mid-stream: immediate effect, restart at 0
  task automatic test_async_reset();
    do_reset(1'b1);
    repeat (8) step();
    #3;
    rst = 1'b1;
    #1;
    checks++; if (rom_en !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL async_rst_ctrl: got en=%b valid=%b expected 0 0", rom_en, inst_valid); end
    checks++; if (rom_addr !== 32'h0 || inst_out !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL async_rst_data: got addr=%h out=%h pc=%h expected all 0", rom_addr, inst_out, inst_pc); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k == 1) begin
        checks++; if (rom_en !== 1'b1 || rom_addr !== 32'h0) begin errors++; $display("FAIL async_restart_fetch: got en=%b addr=%h expected en=1 addr=0", rom_en, rom_addr); end
      end
      if (k < 3) begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL async_restart_empty k=%0d: got %b expected 0", k, inst_valid); end
      end else begin
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(k - 3)) begin errors++; $display("FAIL async_restart_inst k=%0d: got v=%b pc=%h expected %h", k, inst_valid, inst_pc, 32'(k - 3)); end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, the first fetch address after reset.
REQ-002 SHALL have parameter PC_STEP, default 1, the word-address increment per sequential fetch.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port rom_addr  output  32  fetch address driven to the instruction ROM.
REQ-006 SHALL have port rom_en  output  1  fetch request; high means rom_addr is a valid read this cycle.
REQ-007 SHALL have port rom_data  input  32  ROM read data, valid exactly one cycle after the rom_en cycle.
REQ-008 SHALL have port redirect  input  1  one-cycle pulse to restart fetch at redirect_pc.
REQ-009 SHALL have port redirect_pc  input  32  target address, sampled when redirect=1.
REQ-010 SHALL have port halt  input  1  level; while high, no new fetch is issued.
REQ-011 SHALL have port inst_valid  output  1  inst_out/inst_pc hold a valid instruction.
REQ-012 SHALL have port inst_ready  input  1  consumer accepts the instruction when inst_valid&inst_ready.
REQ-013 SHALL have port inst_out  output  32  instruction word at the head of the queue.
REQ-014 SHALL have port inst_pc  output  32  address the head instruction was fetched from.

Function
REQ-015 SHALL implement states INIT, RUN and HALTED: INIT->RUN after one cycle; RUN->HALTED when halt=1; HALTED->RUN when halt=0; any state->RUN on redirect.
REQ-016 SHALL keep a 2-entry FIFO of {pc, instruction} plus a 1-bit in-flight flag for the request issued in the previous cycle.
REQ-017 SHALL assert rom_en in RUN only when (fifo_count + inflight - pop) < 2, where pop = inst_valid&inst_ready.
REQ-018 SHALL drive rom_addr = fetch PC and, on each issued request, advance the fetch PC by PC_STEP with 32-bit wrap-around (32'hFFFFFFFF + 1 -> 0).
REQ-019 SHALL write rom_data and its request address into the FIFO on the cycle after an issued request, unless that request was killed.
REQ-020 SHALL drive inst_valid = (fifo_count != 0), with inst_out/inst_pc taken from the FIFO head.
REQ-021 SHALL, with a full FIFO, hold inst_out/inst_pc stable and issue no request until a pop occurs.
REQ-022 SHALL allow a push and a pop in the same cycle, leaving the count unchanged and the order preserved.
REQ-023 SHALL, on redirect: flush the FIFO, kill the in-flight response, load the fetch PC with redirect_pc, and issue redirect_pc on the next cycle (rom_en=0 during the redirect cycle).
REQ-024 SHALL let redirect win over halt and over a simultaneous pop, push or issue.
REQ-025 SHALL, while halt=1, still capture the in-flight response and still present and pop FIFO contents.
REQ-026 SHALL guarantee that a back-to-back consumer (inst_ready=1 always) sees one instruction per cycle in steady state, in fetch order, with no duplicates or gaps.

Reset
REQ-027 SHALL, on rst=1 and independent of clk, force: state=INIT, fetch PC=RESET_PC, FIFO empty, inflight=0, rom_en=0, inst_valid=0, rom_addr=RESET_PC, inst_out=0, inst_pc=0.
REQ-028 SHALL discard any in-flight or queued instruction when reset is asserted mid-operation, and restart fetch from RESET_PC.

Verification
REQ-029 SHALL be verified with: reset, then inst_ready=1 against a ROM returning data=addr -> rom_addr 0,1,2,...; first inst_valid 3 cycles after reset release with inst_pc=0 and inst_out=0; then one instruction per cycle.
REQ-030 SHALL be verified with: inst_ready=0 for 5 cycles -> FIFO holds pc 0,1; rom_en drops to 0; inst_out stays 0; on inst_ready=1, instructions 0,1,2 follow consecutively.
REQ-031 SHALL be verified with: redirect=1 with redirect_pc=32'h40 while an instruction is in flight -> next inst_pc=32'h40; no stale instruction is delivered.
REQ-032 SHALL be verified with: halt=1 for 4 cycles -> rom_en=0; queued instructions drain; fetch resumes at the next sequential PC after halt=0.
REQ-033 SHALL be verified with: redirect_pc=32'hFFFFFFFF -> inst_pc sequence FFFFFFFF, 00000000, 00000001.
REQ-034 SHALL be verified with: rst pulsed between clock edges mid-stream -> outputs match the REQ-027 values immediately, and fetch restarts at RESET_PC.
